grf_wb_arb: RTL and testbench



---
 rtl/grf_wb_arb_pkg.sv | 14 +
 rtl/grf_wb_arb_wb_buf.sv | 78 +++++++
 rtl/grf_wb_arb.sv | 87 ++++++++
 tb/tb_grf_wb_arb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_arb_pkg.sv
// rtl/grf_wb_arb_pkg.sv - shared widths and buffer-entry type for the GRF write arbiter
package grf_wb_arb_pkg;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_arb_wb_buf.sv
// rtl/grf_wb_arb_wb_buf.sv - MDU result FIFO with kill-by-address and per-entry valid/a3 view
module wb_buf
  import grf_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_a3_i,
  input  logic [DW-1:0]            push_wd_i,
  input  logic                     pop_i,
  input  logic                     kill_en_i,
  input  logic [AW-1:0]            kill_a3_i,
  output logic                     full_o,
  output logic                     empty_o,
  output wb_entry_t                head_o,
  output logic [DEPTH-1:0]         ent_valid_o,
  output logic [DEPTH-1:0][AW-1:0] ent_a3_o
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     ent_q [DEPTH];
  wb_entry_t     ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (kill_en_i && ent_q[i].a3 == kill_a3_i) begin
        ent_d[i].valid = 1'b0;
      end
    end
    // Popped slots are invalidated so the valid view only covers occupied entries.
    if (pop_i) begin
      ent_d[head_q].valid = 1'b0;
    end
    if (push_i) begin
      ent_d[tail_q] = '{valid: 1'b1, a3: push_a3_i, wd: push_wd_i};
    end
    head_d  = head_q + PW'(pop_i);
    tail_d  = tail_q + PW'(push_i);
    count_d = count_q + (PW + 1)'(push_i) - (PW + 1)'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid_o[i] = ent_q[i].valid;
      ent_a3_o[i]    = ent_q[i].a3;
    end
  end

  assign full_o  = (count_q == (PW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = ent_q[head_q];

endmodule

// File: rtl/grf_wb_arb.sv
// rtl/grf_wb_arb.sv - GRF write-port arbiter: pipeline first, then buffered MDU, then direct MDU
module grf_wb_arb
  import grf_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we_i,
  input  logic [AW-1:0] pipe_a3_i,
  input  logic [DW-1:0] pipe_wd_i,
  input  logic          mdu_valid_i,
  input  logic [AW-1:0] mdu_a3_i,
  input  logic [DW-1:0] mdu_wd_i,
  output logic          mdu_ready_o,
  output logic          grf_we_o,
  output logic [AW-1:0] grf_a3_o,
  output logic [DW-1:0] grf_wd_o,
  output logic [31:0]   pend_mask_o
);

  logic                     buf_full, buf_empty;
  wb_entry_t                buf_head;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_a3;
  logic                     pipe_wr, mdu_hs, mdu_nz, buf_pop, mdu_direct, buf_push;
  logic [31:0]              pend;

  assign mdu_ready_o = !reset && !buf_full;
  assign pipe_wr     = !reset && pipe_we_i && (pipe_a3_i != REG_ZERO);
  assign mdu_hs      = mdu_valid_i && mdu_ready_o;
  assign mdu_nz      = (mdu_a3_i != REG_ZERO);
  assign buf_pop     = !reset && !pipe_wr && !buf_empty;
  assign mdu_direct  = !pipe_wr && buf_empty && mdu_hs && mdu_nz;
  // A same-cycle pipe write to the same register is younger, so the MDU result is dead.
  assign buf_push    = mdu_hs && mdu_nz && !mdu_direct && !(pipe_wr && pipe_a3_i == mdu_a3_i);

  wb_buf #(.DEPTH(DEPTH)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (buf_push),
    .push_a3_i   (mdu_a3_i),
    .push_wd_i   (mdu_wd_i),
    .pop_i       (buf_pop),
    .kill_en_i   (pipe_wr),
    .kill_a3_i   (pipe_a3_i),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .head_o      (buf_head),
    .ent_valid_o (ent_valid),
    .ent_a3_o    (ent_a3)
  );

  always_comb begin
    grf_we_o = 1'b0;
    grf_a3_o = '0;
    grf_wd_o = '0;
    if (pipe_wr) begin
      grf_we_o = 1'b1;
      grf_a3_o = pipe_a3_i;
      grf_wd_o = pipe_wd_i;
    end else if (buf_pop) begin
      if (buf_head.valid) begin
        grf_we_o = 1'b1;
        grf_a3_o = buf_head.a3;
        grf_wd_o = buf_head.wd;
      end
    end else if (mdu_direct) begin
      grf_we_o = 1'b1;
      grf_a3_o = mdu_a3_i;
      grf_wd_o = mdu_wd_i;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        pend[ent_a3[i]] = 1'b1;
      end
    end
    pend[0] = 1'b0;
  end

  assign pend_mask_o = reset ? '0 : pend;

endmodule

// File: tb/tb_grf_wb_arb.sv
// tb/tb_grf_wb_arb.sv - directed self-checking bench for grf_wb_arb
module tb_grf_wb_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd;
  logic        mdu_valid;
  logic [4:0]  mdu_a3;
  logic [31:0] mdu_wd;
  logic        mdu_ready;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] pend_mask;

  logic [31:0] shadow [32];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  grf_wb_arb #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_we_i   (pipe_we),
    .pipe_a3_i   (pipe_a3),
    .pipe_wd_i   (pipe_wd),
    .mdu_valid_i (mdu_valid),
    .mdu_a3_i    (mdu_a3),
    .mdu_wd_i    (mdu_wd),
    .mdu_ready_o (mdu_ready),
    .grf_we_o    (grf_we),
    .grf_a3_o    (grf_a3),
    .grf_wd_o    (grf_wd),
    .pend_mask_o (pend_mask)
  );

  always @(posedge clk) begin
    if (grf_we) shadow[grf_a3] <= grf_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc(input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd,
                     input logic mv, input logic [4:0] ma3, input logic [31:0] mwd);
    @(negedge clk);
    pipe_we = pwe; pipe_a3 = pa3; pipe_wd = pwd;
    mdu_valid = mv; mdu_a3 = ma3; mdu_wd = mwd;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    reset = 1'b1;
    pipe_we = 1'b0; pipe_a3 = '0; pipe_wd = '0;
    mdu_valid = 1'b0; mdu_a3 = '0; mdu_wd = '0;

    // 1: reset with MDU presenting, then direct write on release
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0000_0055);
    edge_wait();
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0000_0055);
    check("rst_we", {31'b0, grf_we}, 32'h0);
    check("rst_ready", {31'b0, mdu_ready}, 32'h0);
    check("rst_a3", {27'b0, grf_a3}, 32'h0);
    edge_wait();
    check("rst_pend", pend_mask, 32'h0);
    reset = 1'b0;
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0000_0055);
    check("rel_ready", {31'b0, mdu_ready}, 32'h1);
    check("rel_we", {31'b0, grf_we}, 32'h1);
    check("rel_a3", {27'b0, grf_a3}, 32'd5);
    check("rel_wd", grf_wd, 32'h0000_0055);

    // 2: direct MDU write
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0000_1234);
    check("dir_we", {31'b0, grf_we}, 32'h1);
    check("dir_a3", {27'b0, grf_a3}, 32'd5);
    check("dir_wd", grf_wd, 32'h0000_1234);
    edge_wait();
    check("dir_pend", pend_mask, 32'h0);

    // 3: collision, MDU buffered one cycle
    cyc(1'b1, 5'd3, 32'hAAAA_0000, 1'b1, 5'd7, 32'hBBBB_0000);
    check("col_a3", {27'b0, grf_a3}, 32'd3);
    check("col_wd", grf_wd, 32'hAAAA_0000);
    edge_wait();
    check("col_pend", pend_mask, 32'h0000_0080);
    idle();
    check("drn_we", {31'b0, grf_we}, 32'h1);
    check("drn_a3", {27'b0, grf_a3}, 32'd7);
    check("drn_wd", grf_wd, 32'hBBBB_0000);
    edge_wait();
    check("drn_pend", pend_mask, 32'h0);

    // 4: fill to full under pipe pressure, then drain in order
    cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA);
    check("f0_ready", {31'b0, mdu_ready}, 32'h1);
    check("f0_a3", {27'b0, grf_a3}, 32'd1);
    cyc(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB);
    check("f1_ready", {31'b0, mdu_ready}, 32'h1);
    edge_wait();
    check("f1_pend", pend_mask, 32'h0000_0C00);
    cyc(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hC);
    check("f2_ready", {31'b0, mdu_ready}, 32'h0);
    cyc(1'b1, 5'd4, 32'h4, 1'b1, 5'd12, 32'hC);
    check("f3_ready", {31'b0, mdu_ready}, 32'h0);
    check("f3_a3", {27'b0, grf_a3}, 32'd4);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC);
    check("f4_ready", {31'b0, mdu_ready}, 32'h0);
    check("f4_a3", {27'b0, grf_a3}, 32'd10);
    check("f4_wd", grf_wd, 32'hA);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC);
    check("f5_ready", {31'b0, mdu_ready}, 32'h1);
    check("f5_a3", {27'b0, grf_a3}, 32'd11);
    check("f5_wd", grf_wd, 32'hB);
    edge_wait();
    check("f5_pend", pend_mask, 32'h0000_1000);
    idle();
    check("f6_we", {31'b0, grf_we}, 32'h1);
    check("f6_a3", {27'b0, grf_a3}, 32'd12);
    check("f6_wd", grf_wd, 32'hC);
    edge_wait();
    check("f6_pend", pend_mask, 32'h0);

    // 5: younger pipe write kills buffered $9
    cyc(1'b1, 5'd8, 32'h8, 1'b1, 5'd9, 32'h1);
    edge_wait();
    check("k_pend_set", pend_mask, 32'h0000_0200);
    cyc(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0);
    check("k_a3", {27'b0, grf_a3}, 32'd9);
    edge_wait();
    check("k_pend_clr", pend_mask, 32'h0);
    idle();
    check("k_drain_we", {31'b0, grf_we}, 32'h0);
    check("k_drain_a3", {27'b0, grf_a3}, 32'h0);
    edge_wait();
    check("k_final9", shadow[9], 32'h2);

    // 6: $0 handling
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
    check("z_ready", {31'b0, mdu_ready}, 32'h1);
    check("z_we", {31'b0, grf_we}, 32'h0);
    edge_wait();
    check("z_pend", pend_mask, 32'h0);
    cyc(1'b1, 5'd0, 32'h77, 1'b1, 5'd4, 32'h44);
    check("z_pipe0_we", {31'b0, grf_we}, 32'h1);
    check("z_pipe0_a3", {27'b0, grf_a3}, 32'd4);
    check("z_pipe0_wd", grf_wd, 32'h44);
    idle();
    check("z_idle_we", {31'b0, grf_we}, 32'h0);

    // reset mid-drain drops buffered results
    cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd6, 32'h66);
    edge_wait();
    check("r_pend_set", pend_mask, 32'h0000_0040);
    reset = 1'b1;
    idle();
    check("r_we", {31'b0, grf_we}, 32'h0);
    check("r_ready", {31'b0, mdu_ready}, 32'h0);
    edge_wait();
    reset = 1'b0;
    idle();
    check("r_after_we", {31'b0, grf_we}, 32'h0);
    check("r_after_pend", pend_mask, 32'h0);
    check("r_after_ready", {31'b0, mdu_ready}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
